// File: rtl/spi_cmd_pkg.sv
// Shared types, frame layout and checksum helper for the SPI command decoder.
// Frames and status words both carry a nibble-XOR checksum in bits [3:0].
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP        = 2'd0,
    OP_SET_TARGET = 2'd1,
    OP_SET_MODE   = 2'd2,
    OP_RESET_ERR  = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    MODE_SAFE   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_TRACK  = 2'd2,
    MODE_SCAN   = 2'd3
  } mode_e;

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_e;

  localparam logic [1:0]  SYNC         = 2'b10;
  localparam logic [1:0]  STATUS_SYNC  = 2'b01;
  localparam logic [11:0] RESET_TARGET = 12'h800;

  localparam int SYNC_HI = 31;
  localparam int SYNC_LO = 30;
  localparam int OP_HI   = 29;
  localparam int OP_LO   = 28;
  localparam int FA_HI   = 27;
  localparam int FA_LO   = 16;
  localparam int FB_HI   = 15;
  localparam int FB_LO   = 4;
  localparam int CHK_HI  = 3;
  localparam int CHK_LO  = 0;

  // XOR of the seven nibbles above the checksum field.
  function automatic logic [3:0] nibble_xor(input logic [31:0] w);
    logic [3:0] acc;
    acc = '0;
    for (int i = 1; i < 8; i++) begin
      acc = acc ^ w[i*4 +: 4];
    end
    return acc;
  endfunction

endpackage

// File: rtl/spi_frame_chk.sv
// Combinational sync and checksum check of one 32-bit SPI frame.
module spi_frame_chk
  import spi_cmd_pkg::*;
(
  input  logic [31:0] frame,
  output logic        sync_ok,
  output logic        chk_ok
);

  always_comb begin
    sync_ok = (frame[SYNC_HI:SYNC_LO] == SYNC);
    chk_ok  = (frame[CHK_HI:CHK_LO] == nibble_xor(frame));
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Two-stage SPI command decoder: stage 1 captures frame and check result,
// stage 2 applies commands, tracks link health and builds the status reply.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = 10_000_000,
  parameter int unsigned BAD_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic [11:0] pan_target,
  output logic [11:0] tilt_target,
  output logic [1:0]  mode,
  output logic        laser_en,
  output logic        cmd_update,
  output logic        link_ok,
  output logic [7:0]  err_count,
  output logic [31:0] status_frame
);

  localparam int unsigned       WDT_W    = $clog2(WDT_CYCLES + 1);
  localparam int unsigned       BAD_W    = $clog2(BAD_LIMIT + 1);
  localparam logic [WDT_W-1:0]  WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(BAD_LIMIT);

  function automatic logic [31:0] pack_status(input logic        link,
                                              input logic        laser,
                                              input logic [1:0]  md,
                                              input logic [7:0]  err,
                                              input logic [1:0]  op,
                                              input logic [11:0] pan);
    logic [31:0] w;
    w = {STATUS_SYNC, link, laser, md, err, op, pan, 4'h0};
    w[3:0] = nibble_xor(w);
    return w;
  endfunction

  logic              sync_ok, chk_ok;
  logic              vld_p1_d, vld_p1_q;
  logic              good_p1_d, good_p1_q;
  logic [31:0]       frame_p1_d, frame_p1_q;

  link_state_e       state_d, state_q;
  logic [WDT_W-1:0]  wdt_d, wdt_q;
  logic [BAD_W-1:0]  bad_run_d, bad_run_q;
  logic [7:0]        err_count_d, err_count_q;
  logic [11:0]       pan_d, pan_q;
  logic [11:0]       tilt_d, tilt_q;
  mode_e             mode_d, mode_q;
  logic              laser_d, laser_q;
  logic              cmd_update_d, cmd_update_q;
  opcode_e           last_op_d, last_op_q;
  logic [31:0]       status_d, status_q;

  logic              apply_good, apply_bad;
  opcode_e           op_p1;
  logic [11:0]       field_a_p1, field_b_p1;

  spi_frame_chk u_rx_chk (
    .frame   (rx_data),
    .sync_ok (sync_ok),
    .chk_ok  (chk_ok)
  );

  // Stage 1: capture the frame and its check verdict
  always_comb begin
    vld_p1_d   = rx_valid;
    good_p1_d  = sync_ok & chk_ok;
    frame_p1_d = rx_data;
  end

  always_ff @(posedge clk) begin
    frame_p1_q <= frame_p1_d;
  end

  assign apply_good = vld_p1_q & good_p1_q;
  assign apply_bad  = vld_p1_q & ~good_p1_q;
  assign op_p1      = opcode_e'(frame_p1_q[OP_HI:OP_LO]);
  assign field_a_p1 = frame_p1_q[FA_HI:FA_LO];
  assign field_b_p1 = frame_p1_q[FB_HI:FB_LO];

  // Stage 2: apply command, link supervision, status reply
  always_comb begin
    state_d      = state_q;
    wdt_d        = wdt_q;
    bad_run_d    = bad_run_q;
    err_count_d  = err_count_q;
    pan_d        = pan_q;
    tilt_d       = tilt_q;
    mode_d       = mode_q;
    laser_d      = laser_q;
    last_op_d    = last_op_q;
    cmd_update_d = 1'b0;

    if (apply_good) begin
      bad_run_d = '0;
      wdt_d     = '0;
      last_op_d = op_p1;
      case (op_p1)
        OP_SET_TARGET: begin
          pan_d        = field_a_p1;
          tilt_d       = field_b_p1;
          cmd_update_d = 1'b1;
        end
        OP_SET_MODE: begin
          mode_d       = mode_e'(field_a_p1[1:0]);
          laser_d      = field_a_p1[2];
          cmd_update_d = 1'b1;
        end
        OP_RESET_ERR: err_count_d = '0;
        default: ;
      endcase
    end else if (apply_bad) begin
      err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
      bad_run_d   = (bad_run_q == BAD_MAX) ? bad_run_q : bad_run_q + BAD_W'(1);
    end

    case (state_q)
      LINK_DOWN: begin
        wdt_d = '0;
        if (apply_good) state_d = LINK_UP;
      end
      LINK_UP: begin
        // A good frame in the expiry cycle keeps the link alive.
        if (!apply_good) begin
          wdt_d = wdt_q + WDT_W'(1);
          if (wdt_q == WDT_LAST || bad_run_d == BAD_MAX) begin
            state_d      = LINK_DOWN;
            wdt_d        = '0;
            mode_d       = MODE_SAFE;
            laser_d      = 1'b0;
            cmd_update_d = 1'b1;
          end
        end
      end
      default: state_d = LINK_DOWN;
    endcase

    status_d = pack_status(state_d == LINK_UP, laser_d, mode_d, err_count_d,
                           last_op_d, pan_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q     <= 1'b0;
      good_p1_q    <= 1'b0;
      state_q      <= LINK_DOWN;
      wdt_q        <= '0;
      bad_run_q    <= '0;
      err_count_q  <= '0;
      pan_q        <= RESET_TARGET;
      tilt_q       <= RESET_TARGET;
      mode_q       <= MODE_SAFE;
      laser_q      <= 1'b0;
      last_op_q    <= OP_NOP;
      cmd_update_q <= 1'b0;
      status_q     <= pack_status(1'b0, 1'b0, MODE_SAFE, 8'h00, OP_NOP, RESET_TARGET);
    end else begin
      vld_p1_q     <= vld_p1_d;
      good_p1_q    <= good_p1_d;
      state_q      <= state_d;
      wdt_q        <= wdt_d;
      bad_run_q    <= bad_run_d;
      err_count_q  <= err_count_d;
      pan_q        <= pan_d;
      tilt_q       <= tilt_d;
      mode_q       <= mode_d;
      laser_q      <= laser_d;
      last_op_q    <= last_op_d;
      cmd_update_q <= cmd_update_d;
      status_q     <= status_d;
    end
  end

  assign pan_target   = pan_q;
  assign tilt_target  = tilt_q;
  assign mode         = mode_q;
  assign laser_en     = laser_q;
  assign cmd_update   = cmd_update_q;
  assign link_ok      = (state_q == LINK_UP);
  assign err_count    = err_count_q;
  assign status_frame = status_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: a behavioural model predicts the full
// output set per cycle; a negedge monitor pops and compares.
module tb_spi_cmd_decoder;

  localparam int WDT   = 16;
  localparam int BLIM  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [11:0] pan_target, tilt_target;
  logic [1:0]  mode;
  logic        laser_en, cmd_update, link_ok;
  logic [7:0]  err_count;
  logic [31:0] status_frame;

  spi_cmd_decoder #(.WDT_CYCLES(WDT), .BAD_LIMIT(BLIM)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .pan_target   (pan_target),
    .tilt_target  (tilt_target),
    .mode         (mode),
    .laser_en     (laser_en),
    .cmd_update   (cmd_update),
    .link_ok      (link_ok),
    .err_count    (err_count),
    .status_frame (status_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pan;
    logic [11:0] tilt;
    logic [1:0]  mode;
    logic        laser;
    logic        cmd;
    logic        link;
    logic [7:0]  err;
    logic [31:0] status;
  } snap_t;

  snap_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 0;

  // Behavioural model state
  logic [11:0] m_pan, m_tilt;
  logic [1:0]  m_mode, m_last_op;
  logic        m_laser, m_link, m_cmd;
  int          m_err, m_bad, m_since;

  function automatic logic [3:0] tb_chk(input logic [31:0] w);
    logic [3:0] r = 4'h0;
    for (int i = 1; i < 8; i++) r = r ^ w[i*4 +: 4];
    return r;
  endfunction

  function automatic logic [31:0] make_frame(input logic [1:0] op, input logic [11:0] a,
                                             input logic [11:0] b);
    logic [31:0] w;
    w = {2'b10, op, a, b, 4'h0};
    w[3:0] = tb_chk(w);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pan = 12'h800; m_tilt = 12'h800; m_mode = 2'd0; m_last_op = 2'd0;
    m_laser = 0; m_link = 0; m_cmd = 0; m_err = 0; m_bad = 0; m_since = 0;
  endtask

  function automatic snap_t snap();
    snap_t s;
    logic [31:0] st;
    s.pan = m_pan; s.tilt = m_tilt; s.mode = m_mode; s.laser = m_laser;
    s.cmd = m_cmd; s.link = m_link; s.err = 8'(m_err);
    st = {2'b01, m_link, m_laser, m_mode, 8'(m_err), m_last_op, m_pan, 4'h0};
    st[3:0] = tb_chk(st);
    s.status = st;
    return s;
  endfunction

  // One apply-step of the reference: the frame's effect after the pipeline.
  task automatic model_step(input bit v, input logic [31:0] w);
    bit good;
    m_cmd = 0;
    good = v && (w[31:30] == 2'b10) && (tb_chk(w) == w[3:0]);
    if (good) begin
      m_bad = 0; m_since = 0; m_link = 1; m_last_op = w[29:28];
      case (w[29:28])
        2'd1: begin m_pan = w[27:16]; m_tilt = w[15:4]; m_cmd = 1; end
        2'd2: begin m_mode = w[17:16]; m_laser = w[18]; m_cmd = 1; end
        2'd3: m_err = 0;
        default: ;
      endcase
    end else begin
      if (v) begin
        if (m_err < 255) m_err++;
        if (m_bad < BLIM) m_bad++;
      end
      if (m_link) begin
        m_since++;
        if (m_since >= WDT || m_bad >= BLIM) begin
          m_link = 0; m_mode = 2'd0; m_laser = 0; m_cmd = 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] w);
    rx_valid = v;
    rx_data  = v ? w : $urandom();
    model_step(v, w);
    exp_q.push_back(snap());
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pan"}, 32'(pan_target), 32'h800);
    chk({tag, "_tilt"}, 32'(tilt_target), 32'h800);
    chk({tag, "_mode"}, 32'(mode), 32'h0);
    chk({tag, "_laser"}, 32'(laser_en), 32'h0);
    chk({tag, "_cmd"}, 32'(cmd_update), 32'h0);
    chk({tag, "_link"}, 32'(link_ok), 32'h0);
    chk({tag, "_err"}, 32'(err_count), 32'h0);
    chk({tag, "_status"}, status_frame, 32'h4000_800C);
  endtask

  task automatic reset_and_check(input string tag);
    mon_en = 0;
    exp_q.delete();
    rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals({tag, "_async"});
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals({tag, "_held"});
    reset = 1'b0;
    model_reset();
    exp_q.push_back(snap());
    exp_q.push_back(snap());
    mon_en = 1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        snap_t e;
        e = exp_q.pop_front();
        chk("sb_pan", 32'(pan_target), 32'(e.pan));
        chk("sb_tilt", 32'(tilt_target), 32'(e.tilt));
        chk("sb_mode", 32'(mode), 32'(e.mode));
        chk("sb_laser", 32'(laser_en), 32'(e.laser));
        chk("sb_cmd_update", 32'(cmd_update), 32'(e.cmd));
        chk("sb_link_ok", 32'(link_ok), 32'(e.link));
        chk("sb_err_count", 32'(err_count), 32'(e.err));
        chk("sb_status", status_frame, e.status);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset_and_check("rst0");

    // Set target from reset
    cycle(1, 32'h9123_456E);
    cycle(0, 0);
    chk("t035_pan", 32'(pan_target), 32'h123);
    chk("t035_tilt", 32'(tilt_target), 32'h456);
    chk("t035_cmd", 32'(cmd_update), 32'h1);
    chk("t035_link", 32'(link_ok), 32'h1);

    // Set mode TRACK with laser
    cycle(1, 32'hA006_000C);
    cycle(0, 0);
    chk("t036_mode", 32'(mode), 32'h2);
    chk("t036_laser", 32'(laser_en), 32'h1);
    chk("t036_status", 32'(status_frame[29:26]), 32'hE);

    // Three bad frames drop the link, RESET_ERR clears the count
    repeat (3) cycle(1, 32'h9123_456F);
    cycle(0, 0);
    chk("t037_err", 32'(err_count), 32'd3);
    chk("t037_link", 32'(link_ok), 32'h0);
    chk("t037_mode", 32'(mode), 32'h0);
    chk("t037_laser", 32'(laser_en), 32'h0);
    chk("t037_pan", 32'(pan_target), 32'h123);
    chk("t037_tilt", 32'(tilt_target), 32'h456);
    cycle(1, 32'hB000_000B);
    cycle(0, 0);
    chk("t037_err_clr", 32'(err_count), 32'd0);

    // Watchdog expiry 16 cycles after the apply cycle
    cycle(1, 32'h8000_0008);
    cycle(0, 0);
    repeat (15) cycle(0, 0);
    chk("t038_link_15", 32'(link_ok), 32'h1);
    cycle(0, 0);
    chk("t038_link_16", 32'(link_ok), 32'h0);
    chk("t038_cmd_16", 32'(cmd_update), 32'h1);

    // Good frame in the expiry cycle wins
    cycle(1, 32'hA006_000C);
    cycle(0, 0);
    repeat (14) cycle(0, 0);
    cycle(1, 32'h8000_0008);
    cycle(0, 0);
    chk("t038_keep_link", 32'(link_ok), 32'h1);
    chk("t038_keep_mode", 32'(mode), 32'h2);
    chk("t038_keep_laser", 32'(laser_en), 32'h1);
    chk("t038_keep_cmd", 32'(cmd_update), 32'h0);

    // Error counter saturation
    repeat (300) cycle(1, 32'h9123_456F);
    cycle(0, 0);
    cycle(0, 0);
    chk("t039_err_sat", 32'(err_count), 32'd255);

    // Reset with a frame in flight
    cycle(1, 32'h9123_456E);
    reset_and_check("t040");
    repeat (3) cycle(0, 0);
    chk("t040_pan", 32'(pan_target), 32'h800);
    chk("t040_link", 32'(link_ok), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [31:0] w;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        repeat ($urandom_range(5, 20)) cycle(0, 0);
      end else if (kind <= 6) begin
        w = make_frame(2'($urandom_range(0, 3)), 12'($urandom()), 12'($urandom()));
        cycle(1, w);
        if ($urandom_range(0, 2) == 0) cycle(0, 0);
      end else begin
        w = make_frame(2'($urandom_range(0, 3)), 12'($urandom()), 12'($urandom()));
        w = w ^ (32'h1 << $urandom_range(0, 31));
        cycle(1, w);
      end
    end
    repeat (3) cycle(0, 0);
    @(negedge clk);
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
